// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: round-robin arbiter sequencing two requesters onto a single-port RAM
module ram_access_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ0,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] WDATA0,
  output logic              ACK0,
  input  logic              REQ1,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              ACK1,
  output logic [DATA_W-1:0] RDATA,
  output logic              BUSY,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_CS,
  output logic              RAM_OE,
  output logic              RAM_WS,
  inout  wire  [DATA_W-1:0] RAM_DATA
);
  typedef enum logic [2:0] {IDLE, W_SETUP, W_STROBE, W_HOLD, R_ACCESS, R_SAMPLE, DONE} state_t;
  state_t state;
  logic last, sel, drive, gnt, gnt_we;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata, wd;
  always_comb begin
    gnt = (REQ0 && REQ1) ? !last : REQ1;
    gnt_we = gnt ? WE1 : WE0;
    gnt_addr = gnt ? ADDR1 : ADDR0;
    gnt_wdata = gnt ? WDATA1 : WDATA0;
  end
  assign RAM_DATA = drive ? wd : 'z;
  always_ff @(posedge CLK)
    if (!RST_N) begin
      state <= IDLE;
      last <= 1'b1;
      sel <= 1'b0;
      drive <= 1'b0;
      wd <= '0;
      ACK0 <= 1'b0;
      ACK1 <= 1'b0;
      RDATA <= '0;
      BUSY <= 1'b0;
      RAM_ADDR <= '0;
      RAM_CS <= 1'b0;
      RAM_OE <= 1'b0;
      RAM_WS <= 1'b0;
    end else
      case (state)
        IDLE: if (REQ0 || REQ1) begin
          state <= gnt_we ? W_SETUP : R_ACCESS;
          sel <= gnt;
          last <= gnt;
          BUSY <= 1'b1;
          RAM_ADDR <= gnt_addr;
          wd <= gnt_wdata;
          drive <= gnt_we;
          RAM_OE <= gnt_we;
          RAM_CS <= !gnt_we;
        end
        W_SETUP: begin
          state <= W_STROBE;
          RAM_WS <= 1'b1;
        end
        W_STROBE: begin
          state <= W_HOLD;
          RAM_WS <= 1'b0;
        end
        W_HOLD: begin
          state <= DONE;
          drive <= 1'b0;
          RAM_OE <= 1'b0;
          RAM_ADDR <= '0;
          ACK0 <= !sel;
          ACK1 <= sel;
        end
        R_ACCESS: state <= R_SAMPLE;
        R_SAMPLE: begin
          state <= DONE;
          RAM_CS <= 1'b0;
          RAM_ADDR <= '0;
          RDATA <= RAM_DATA;
          ACK0 <= !sel;
          ACK1 <= sel;
        end
        DONE: begin
          state <= IDLE;
          ACK0 <= 1'b0;
          ACK1 <= 1'b0;
          BUSY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: randomized and directed checks of ram_access_arbiter against a memory/grant model
module tb_ram_access_arbiter;
  logic CLK = 0, RST_N = 0, REQ0 = 0, WE0 = 0, REQ1 = 0, WE1 = 0;
  logic [31:0] ADDR0 = 0, ADDR1 = 0;
  logic [7:0] WDATA0 = 0, WDATA1 = 0;
  wire ACK0, ACK1, BUSY, RAM_CS, RAM_OE, RAM_WS;
  wire [7:0] RDATA;
  wire [31:0] RAM_ADDR;
  wire [7:0] RAM_DATA;
  logic [7:0] ram [32];
  logic [7:0] exp_mem [32];
  logic [7:0] last_rd = 0;
  logic p0 = 0, p1 = 0;
  int ws_count = 0, bus_viol = 0, ack_viol = 0, ack_count = 0;
  int checks = 0, errors = 0, last_g = 1;
  ram_access_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .ACK0(ACK0),
    .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .ACK1(ACK1),
    .RDATA(RDATA), .BUSY(BUSY), .RAM_ADDR(RAM_ADDR), .RAM_CS(RAM_CS),
    .RAM_OE(RAM_OE), .RAM_WS(RAM_WS), .RAM_DATA(RAM_DATA)
  );
  always #5 CLK = ~CLK;
  assign RAM_DATA = RAM_CS ? ram[RAM_ADDR[4:0]] : 8'bz;
  always @(posedge RAM_WS) begin
    if (RAM_OE) ram[RAM_ADDR[4:0]] = RAM_DATA;
    ws_count = ws_count + 1;
  end
  always @(negedge CLK) begin
    bus_viol <= bus_viol + int'(RAM_CS && RAM_OE) + int'(RAM_WS && (!RAM_OE || RAM_CS));
    ack_viol <= ack_viol + int'(ACK0 && p0) + int'(ACK1 && p1) + int'(ACK0 && ACK1);
    ack_count <= ack_count + int'(ACK0) + int'(ACK1);
    p0 <= ACK0;
    p1 <= ACK1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic wait_ack(output int who, output int n);
    who = -1;
    n = 0;
    while (who < 0 && n < 30) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if (ACK0) who = 0;
      else if (ACK1) who = 1;
    end
  endtask
  task automatic set_req(input int r, input bit we, input logic [31:0] a, input logic [7:0] d);
    if (r == 0) begin
      REQ0 = 1; WE0 = we; ADDR0 = a; WDATA0 = d;
    end else begin
      REQ1 = 1; WE1 = we; ADDR1 = a; WDATA1 = d;
    end
  endtask
  task automatic drop(input int r);
    if (r == 0) REQ0 = 0;
    else REQ1 = 0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while (BUSY && k < 20) begin
      @(negedge CLK);
      k++;
    end
  endtask
  task automatic run_txn(input int r, input bit we, input logic [31:0] a, input logic [7:0] d);
    int who, n, ws0;
    wait_idle();
    ws0 = ws_count;
    set_req(r, we, a, d);
    wait_ack(who, n);
    drop(r);
    chk("grant", who, r);
    chk(we ? "write_latency" : "read_latency", n, we ? 4 : 3);
    if (we) begin
      exp_mem[a[4:0]] = d;
      chk("ram_write", {24'd0, ram[a[4:0]]}, {24'd0, d});
      chk("rdata_hold", {24'd0, RDATA}, {24'd0, last_rd});
    end else begin
      chk("rdata", {24'd0, RDATA}, {24'd0, exp_mem[a[4:0]]});
      last_rd = exp_mem[a[4:0]];
    end
    chk("ws_pulses", ws_count - ws0, we ? 1 : 0);
    last_g = r;
  endtask
  initial begin
    int who, n, expg, ws0, a0;
    for (int i = 0; i < 32; i++) begin
      ram[i] = 8'($urandom);
      exp_mem[i] = ram[i];
    end
    RST_N = 0;
    set_req(0, 0, 3, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_ctrl", {26'd0, ACK0, ACK1, BUSY, RAM_CS, RAM_OE, RAM_WS}, 0);
    chk("reset_rdata", {24'd0, RDATA}, 0);
    chk("reset_addr", RAM_ADDR, 0);
    chk("reset_ws", ws_count, 0);
    RST_N = 1;
    wait_ack(who, n);
    drop(0);
    chk("post_reset_grant", who, 0);
    chk("post_reset_latency", n, 3);
    chk("post_reset_rdata", {24'd0, RDATA}, {24'd0, exp_mem[3]});
    last_rd = exp_mem[3];
    last_g = 0;
    run_txn(0, 1, 5, 8'hA5);
    run_txn(0, 0, 5, 8'h00);
    wait_idle();
    set_req(0, 1, 1, 8'h11);
    set_req(1, 1, 2, 8'h22);
    expg = (last_g == 0) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(who, n);
      chk("rr_grant", who, expg);
      chk("rr_latency", n, i == 0 ? 4 : 5);
      last_g = who;
      expg = 1 - expg;
    end
    drop(0);
    drop(1);
    exp_mem[1] = 8'h11;
    exp_mem[2] = 8'h22;
    chk("rr_mem1", {24'd0, ram[1]}, 32'h11);
    chk("rr_mem2", {24'd0, ram[2]}, 32'h22);
    wait_idle();
    set_req(0, 1, 9, 8'h5A);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("mixed_strobe", {31'd0, RAM_WS}, 1);
    set_req(1, 0, 9, 8'h00);
    wait_ack(who, n);
    drop(0);
    chk("mixed_first", who, 0);
    chk("mixed_first_lat", n, 2);
    wait_ack(who, n);
    drop(1);
    chk("mixed_second", who, 1);
    chk("mixed_second_lat", n, 4);
    chk("mixed_rdata", {24'd0, RDATA}, 32'h5A);
    exp_mem[9] = 8'h5A;
    last_rd = 8'h5A;
    last_g = 1;
    wait_idle();
    ws0 = ws_count;
    a0 = ack_count;
    set_req(0, 1, 7, 8'h3C);
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_setup", {30'd0, BUSY, RAM_OE}, 3);
    RST_N = 0;
    REQ0 = 0;
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_ctrl", {29'd0, BUSY, RAM_OE, RAM_WS}, 0);
    RST_N = 1;
    repeat (6) @(negedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_no_ws", ws_count - ws0, 0);
    chk("abort_no_ack", ack_count - a0, 0);
    last_g = 1;
    last_rd = 0;
    run_txn(0, 0, 7, 8'h00);
    run_txn(0, 1, 31, 8'hFF);
    run_txn(1, 1, 0, 8'h00);
    run_txn(0, 0, 31, 8'h00);
    run_txn(1, 0, 0, 8'h00);
    repeat (24) run_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), 8'($urandom));
    @(posedge CLK);
    @(negedge CLK);
    chk("bus_rules", bus_viol, 0);
    chk("ack_pulses", ack_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
Two-requester round-robin arbiter and access sequencer for the shared single-port RAM.
- Converts clocked request/acknowledge transactions into the RAM strobe sequence on ADDR, RAM_CS, RAM_OE, WS and the bidirectional DATA bus.
- Sits between the datapath masters (e.g. CPU-side port and DMA/test port) and the RAM instance.
- Owns the tristate DATA bus, so no other block drives it.

Parameters:
DATA_W, 8, RAM data width.
ADDR_W, 32, RAM address bus width; matches the RAM address port.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST_N  input  1  synchronous active-low reset.
REQ0  input  1  requester 0 access request, level.
WE0  input  1  requester 0 direction: 1=write, 0=read.
ADDR0  input  ADDR_W  requester 0 address.
WDATA0  input  DATA_W  requester 0 write data.
ACK0  output  1  requester 0 completion, one-cycle pulse.
REQ1, WE1, ADDR1, WDATA1, ACK1  as above, for requester 1.
RDATA  output  DATA_W  read data; valid only in the cycle ACK0 or ACK1 is high for a read.
BUSY  output  1  high in every state except IDLE.
RAM_ADDR  output  ADDR_W  to RAM ADDR.
RAM_CS  output  1  RAM output drive enable; RAM drives DATA while high.
RAM_OE  output  1  RAM write enable, sampled on the WS rising edge.
RAM_WS  output  1  RAM write strobe; write occurs on its rising edge.
RAM_DATA  inout  DATA_W  RAM DATA bus.

Behaviour:
- Reset:
  - One clock with RST_N=0 forces the state to IDLE.
  - Outputs: ACK0=ACK1=0, RDATA=0, BUSY=0, RAM_ADDR=0, RAM_CS=0, RAM_OE=0, RAM_WS=0, RAM_DATA=Z.
  - Priority pointer set so requester 0 wins the first tie.
- Reset mid-operation: abort immediately, next state IDLE with all outputs at reset values.
  - No ACK is issued.
  - RAM_WS never rises due to the abort, so a write in W_SETUP is not committed.
- All outputs are registered.
- Bus rules:
  - The controller drives RAM_DATA only in W_SETUP, W_STROBE and W_HOLD.
  - RAM_CS=1 only in R_ACCESS and R_SAMPLE.
  - RAM_CS and the controller's driver are never active in the same cycle.
- Arbitration in IDLE:
  - Only one requester asserting REQ: it is granted.
  - Both asserting: grant the requester not granted last. The pointer updates on every grant.
  - On grant, latch WE, ADDR and WDATA of the winner. The requester must hold its inputs stable until its ACK.
- FSM states: IDLE, W_SETUP, W_STROBE, W_HOLD, R_ACCESS, R_SAMPLE, DONE.
  - IDLE -> W_SETUP if the granted WE=1; IDLE -> R_ACCESS if WE=0.
  - W_SETUP: RAM_ADDR and RAM_DATA driven, RAM_OE=1, RAM_WS=0.
  - W_STROBE: RAM_WS=1 (this rising edge commits the write), address, data and RAM_OE held.
  - W_HOLD: RAM_WS=0, data, address and RAM_OE held.
  - Write path: W_SETUP -> W_STROBE -> W_HOLD -> DONE.
  - R_ACCESS: RAM_ADDR driven, RAM_CS=1, RAM_OE=0.
  - R_SAMPLE: RAM_CS=1. RDATA captures RAM_DATA at the end of this cycle.
  - Read path: R_ACCESS -> R_SAMPLE -> DONE.
  - DONE: ACK of the granted requester=1 for exactly one cycle. RAM controls return to idle values. Next state is IDLE.
- Latency: request sampled in IDLE at edge N.
  - Write: ACK high in cycle N+4.
  - Read: ACK high in cycle N+3; RDATA stable from that cycle until the next read completes.
- Back-to-back: IDLE always lasts at least one cycle between transactions, so a REQ held through ACK starts a new access. Requesters deassert REQ in the cycle after ACK to avoid a repeat.
- Simultaneous events:
  - A REQ rising while BUSY is held pending, not dropped, and is arbitrated at the next IDLE.
  - A REQ dropped before grant is ignored.

Test Plan:
- Reset: RST_N=0 for 2 cycles with REQ0=1 -> all outputs 0, RAM_DATA=Z, no RAM_WS edge. After release, REQ0 is granted.
- Single write then read: REQ0 write ADDR0=5, WDATA0=8'hA5 -> one RAM_WS pulse with RAM_OE=1, DATA=A5, CS=0; ACK0 at N+4. Then read ADDR0=5 -> RDATA=8'hA5 with ACK0 at N+3.
- Round-robin: REQ0 and REQ1 held continuously with distinct writes (addr 1/2, data 11/22) -> grants alternate 0,1,0,1 and memory ends with [1]=11, [2]=22. Each ACK pulse is 1 cycle.
- Mixed contention: REQ1 read asserted while a requester 0 write is in W_STROBE -> requester 1 served right after IDLE; no cycle has RAM_CS=1 while the controller drives the bus.
- Reset mid-write: RST_N low in W_SETUP of a write of 8'h3C to addr 7 -> RAM_WS stays 0, no ACK, and a later read of addr 7 returns the old value.
- Wrap/boundary: write 8'hFF to address 31 and 8'h00 to address 0, read both back -> FF and 00 with no aliasing.
